meu_serial_subtractor: RTL

- Bit-serial unsigned subtractor computing a_i - b_i - borrow_i with one full-subtractor cell and a borrow register.
- Processes one bit per clock, LSB first, and returns a WIDTH-bit difference plus borrow-out behind a start/done handshake.
- It is the inverse arithmetic counterpart of the team's ripple-carry adder, used where area matters more than latency.
- Its borrow-chained results must match the adder's a + ~b + ~borrow_i form exactly.

---
 rtl/meu_serial_subtractor.sv | 97 +++++++++
 1 files changed

// File: rtl/meu_serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell and a borrow register,
// LSB first, returning a WIDTH-bit difference and borrow-out behind start/done.
module meu_serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             borrow_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_next;
    logic [CW-1:0]    cnt;
    logic             br_q;
    logic             bit_a;
    logic             bit_b;
    logic             d;
    logic             br_next;
    logic             last;

    always_comb begin
        bit_a      = a_q[cnt];
        bit_b      = b_q[cnt];
        d          = bit_a ^ bit_b ^ br_q;
        br_next    = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
        // New bit enters at the MSB so bit 0 reaches the LSB after WIDTH shifts.
        shift_next            = shift_q >> 1;
        shift_next[WIDTH-1]   = d;
        last       = (cnt == CW'(WIDTH - 1));
        state_next = state;
        case (state)
            IDLE:    if (start_i) state_next = SHIFT;
            SHIFT:   if (last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            br_q     <= 1'b0;
            cnt      <= '0;
            shift_q  <= '0;
            diff_o   <= '0;
            borrow_o <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        br_q    <= borrow_i;
                        cnt     <= '0;
                        shift_q <= '0;
                    end
                end
                SHIFT: begin
                    shift_q <= shift_next;
                    br_q    <= br_next;
                    cnt     <= cnt + 1'b1;
                    if (last) begin
                        diff_o   <= shift_next;
                        borrow_o <= br_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o = (state != IDLE);
    assign done_o = (state == DONE);

endmodule
